// File: rtl/morse_pkg.sv
// Shared constants for the Morse keyer: state encoding, symbol codes,
// special character codes and timing multipliers in Morse units.
package morse_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ELEM = 3'd1,
    S_EGAP = 3'd2,
    S_LGAP = 3'd3,
    S_WGAP = 3'd4
  } state_t;

  localparam logic [1:0] SYM_GAP  = 2'd0;
  localparam logic [1:0] SYM_DOT  = 2'd1;
  localparam logic [1:0] SYM_DASH = 2'd2;

  localparam logic [5:0] CODE_SPACE = 6'd36;
  localparam int         MAX_LEN    = 5;

  localparam int MULT_DASH = 3;
  localparam int MULT_EGAP = 1;
  localparam int MULT_LGAP = 3;
  localparam int MULT_WGAP = 7;

endpackage

// File: rtl/morse_rom.sv
// Character code to Morse pattern lookup. Pattern bit 0 is the first
// element sent; a 1 bit is a dash, a 0 bit is a dot.
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0] i_code,
  output logic       o_valid,
  output logic [2:0] o_len,
  output logic [4:0] o_pat
);

  logic [8:0] w_entry;

  // Table of {len, pattern}; a zero length marks a code with no pattern
  always_comb begin
    w_entry = 9'd0;
    case (i_code)
      6'd0:  w_entry = {3'd2, 5'b00010}; // A .-
      6'd1:  w_entry = {3'd4, 5'b00001}; // B -...
      6'd2:  w_entry = {3'd4, 5'b00101}; // C -.-.
      6'd3:  w_entry = {3'd3, 5'b00001}; // D -..
      6'd4:  w_entry = {3'd1, 5'b00000}; // E .
      6'd5:  w_entry = {3'd4, 5'b00100}; // F ..-.
      6'd6:  w_entry = {3'd3, 5'b00011}; // G --.
      6'd7:  w_entry = {3'd4, 5'b00000}; // H ....
      6'd8:  w_entry = {3'd2, 5'b00000}; // I ..
      6'd9:  w_entry = {3'd4, 5'b01110}; // J .---
      6'd10: w_entry = {3'd3, 5'b00101}; // K -.-
      6'd11: w_entry = {3'd4, 5'b00010}; // L .-..
      6'd12: w_entry = {3'd2, 5'b00011}; // M --
      6'd13: w_entry = {3'd2, 5'b00001}; // N -.
      6'd14: w_entry = {3'd3, 5'b00111}; // O ---
      6'd15: w_entry = {3'd4, 5'b00110}; // P .--.
      6'd16: w_entry = {3'd4, 5'b01011}; // Q --.-
      6'd17: w_entry = {3'd3, 5'b00010}; // R .-.
      6'd18: w_entry = {3'd3, 5'b00000}; // S ...
      6'd19: w_entry = {3'd1, 5'b00001}; // T -
      6'd20: w_entry = {3'd3, 5'b00100}; // U ..-
      6'd21: w_entry = {3'd4, 5'b01000}; // V ...-
      6'd22: w_entry = {3'd3, 5'b00110}; // W .--
      6'd23: w_entry = {3'd4, 5'b01001}; // X -..-
      6'd24: w_entry = {3'd4, 5'b01101}; // Y -.--
      6'd25: w_entry = {3'd4, 5'b00011}; // Z --..
      6'd26: w_entry = {3'd5, 5'b11111}; // 0 -----
      6'd27: w_entry = {3'd5, 5'b11110}; // 1 .----
      6'd28: w_entry = {3'd5, 5'b11100}; // 2 ..---
      6'd29: w_entry = {3'd5, 5'b11000}; // 3 ...--
      6'd30: w_entry = {3'd5, 5'b10000}; // 4 ....-
      6'd31: w_entry = {3'd5, 5'b00000}; // 5 .....
      6'd32: w_entry = {3'd5, 5'b00001}; // 6 -....
      6'd33: w_entry = {3'd5, 5'b00011}; // 7 --...
      6'd34: w_entry = {3'd5, 5'b00111}; // 8 ---..
      6'd35: w_entry = {3'd5, 5'b01111}; // 9 ----.
      default: w_entry = 9'd0;
    endcase
  end

  assign o_len   = w_entry[7:5];
  assign o_pat   = w_entry[4:0];
  assign o_valid = (w_entry[7:5] != 3'd0);

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: accepts one character code at a time and plays it out as
// timed dot/dash elements with inter-element, letter and word gaps.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 4,
  parameter int CODE_W      = 6
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [CODE_W-1:0] Code,
  input  logic              InValid,
  output logic              InReady,
  input  logic              Abort,
  output logic              Key,
  output logic [1:0]        Morse,
  output logic              Done,
  output logic              Err,
  output logic [2:0]        OutState
);

  // One counter covers the longest timed state (the 7-unit word gap).
  localparam int CNT_W = (7 * UNIT_CYCLES > 1) ? $clog2(7 * UNIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LD_DOT  = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_DASH = CNT_W'(MULT_DASH * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_EGAP = CNT_W'(MULT_EGAP * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_LGAP = CNT_W'(MULT_LGAP * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_WGAP = CNT_W'(MULT_WGAP * UNIT_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [2:0]       r_idx,   w_idx_nxt;
  logic [2:0]       r_len,   w_len_nxt;
  logic [4:0]       r_pat,   w_pat_nxt;
  logic             r_err,   w_err_nxt;

  logic             w_rom_valid;
  logic [2:0]       w_rom_len;
  logic [4:0]       w_rom_pat;
  logic             w_cur_dash;
  logic             w_cnt_zero;

  morse_rom u_rom (
    .i_code  (Code),
    .o_valid (w_rom_valid),
    .o_len   (w_rom_len),
    .o_pat   (w_rom_pat)
  );

  assign w_cur_dash = r_pat[r_idx];
  assign w_cnt_zero = (r_cnt == '0);

  // State, timer and latched character registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_len   <= 3'd0;
      r_pat   <= 5'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_len   <= w_len_nxt;
      r_pat   <= w_pat_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state, timer reload and character latch; Abort overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_pat_nxt   = r_pat;
    w_err_nxt   = 1'b0;
    if (Abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (InValid) begin
            if (Code == CODE_SPACE) begin
              w_state_nxt = S_WGAP;
              w_cnt_nxt   = LD_WGAP;
            end else if (w_rom_valid) begin
              w_state_nxt = S_ELEM;
              w_pat_nxt   = w_rom_pat;
              w_len_nxt   = w_rom_len;
              w_idx_nxt   = 3'd0;
              w_cnt_nxt   = w_rom_pat[0] ? LD_DASH : LD_DOT;
            end else begin
              w_err_nxt   = 1'b1;
            end
          end
        end
        S_ELEM: begin
          if (!w_cnt_zero) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else if (r_idx == r_len - 3'd1) begin
            w_state_nxt = S_LGAP;
            w_cnt_nxt   = LD_LGAP;
          end else begin
            w_state_nxt = S_EGAP;
            w_cnt_nxt   = LD_EGAP;
            w_idx_nxt   = r_idx + 3'd1;
          end
        end
        S_EGAP: begin
          if (!w_cnt_zero) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else begin
            w_state_nxt = S_ELEM;
            w_cnt_nxt   = w_cur_dash ? LD_DASH : LD_DOT;
          end
        end
        S_LGAP, S_WGAP: begin
          if (!w_cnt_zero) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign Key      = (r_state == S_ELEM);
  assign Morse    = (r_state == S_ELEM) ? (w_cur_dash ? SYM_DASH : SYM_DOT) : SYM_GAP;
  assign InReady  = (r_state == S_IDLE) && !Abort;
  assign Done     = ((r_state == S_LGAP) || (r_state == S_WGAP)) && w_cnt_zero && !Abort;
  assign Err      = r_err;
  assign OutState = r_state;

endmodule

// File: tb/tb_morse_keyer.sv
// Scoreboard bench for morse_keyer with UNIT_CYCLES=2.
module tb_morse_keyer;

  localparam int U = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] code;
  logic       in_valid;
  logic       in_ready;
  logic       abort;
  logic       key;
  logic [1:0] morse;
  logic       done;
  logic       err;
  logic [2:0] out_state;

  int total = 0;
  int bad   = 0;

  // expected per-cycle vector: {InReady, Done, Err, Key, Morse[1:0]}
  logic [5:0] q[$];

  morse_keyer #(.UNIT_CYCLES(U), .CODE_W(6)) dut (
    .Clock    (clk),
    .Resetn   (rstn),
    .Code     (code),
    .InValid  (in_valid),
    .InReady  (in_ready),
    .Abort    (abort),
    .Key      (key),
    .Morse    (morse),
    .Done     (done),
    .Err      (err),
    .OutState (out_state)
  );

  always #5 clk = ~clk;

  function automatic string morse_str(input int c);
    case (c)
      0: return ".-";    1: return "-...";  2: return "-.-.";  3: return "-..";
      4: return ".";     5: return "..-.";  6: return "--.";   7: return "....";
      8: return "..";    9: return ".---";  10: return "-.-";  11: return ".-..";
      12: return "--";   13: return "-.";   14: return "---";  15: return ".--.";
      16: return "--.-"; 17: return ".-.";  18: return "...";  19: return "-";
      20: return "..-";  21: return "...-"; 22: return ".--";  23: return "-..-";
      24: return "-.--"; 25: return "--..";
      26: return "-----"; 27: return ".----"; 28: return "..---"; 29: return "...--";
      30: return "....-"; 31: return "....."; 32: return "-...."; 33: return "--...";
      34: return "---.."; 35: return "----.";
      default: return "";
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push the expected output trace, starting with the cycle after the accept edge.
  task automatic expect_code(input int c);
    string s;
    int    n;
    s = morse_str(c);
    if (c == 36) begin
      for (int i = 0; i < 7*U - 1; i++) q.push_back(6'b000000);
      q.push_back(6'b010000);
      q.push_back(6'b100000);
    end else if (s.len() == 0) begin
      q.push_back(6'b101000);
      q.push_back(6'b100000);
    end else begin
      for (int e = 0; e < s.len(); e++) begin
        n = (s[e] == "-") ? 3*U : U;
        for (int k = 0; k < n; k++) q.push_back((s[e] == "-") ? 6'b000110 : 6'b000101);
        if (e < s.len() - 1) begin
          for (int k = 0; k < U; k++) q.push_back(6'b000000);
        end else begin
          for (int k = 0; k < 3*U - 1; k++) q.push_back(6'b000000);
          q.push_back(6'b010000);
        end
      end
      q.push_back(6'b100000);
    end
  endtask

  task automatic send(input int c);
    @(negedge clk);
    code     = 6'(c);
    in_valid = 1'b1;
    @(posedge clk);
    expect_code(c);
    #1;
    in_valid = 1'b0;
    code     = 6'($urandom_range(0, 63));
  endtask

  // Pop and compare up to n entries (all when n < 0).
  task automatic drain(input string tag, input int n);
    int cyc;
    logic [5:0] e;
    cyc = 1;
    while (q.size() != 0 && (n < 0 || cyc <= n)) begin
      @(negedge clk);
      e = q.pop_front();
      chk($sformatf("%s cyc%0d", tag, cyc), {2'b00, in_ready, done, err, key, morse}, {2'b00, e});
      cyc++;
    end
  endtask

  initial begin
    rstn     = 1'b0;
    code     = 6'd0;
    in_valid = 1'b0;
    abort    = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst key",   {7'd0, key},  8'd0);
    chk("rst morse", {6'd0, morse}, 8'd0);
    chk("rst done",  {7'd0, done}, 8'd0);
    chk("rst err",   {7'd0, err},  8'd0);
    chk("rst state", {5'd0, out_state}, 8'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst ready", {7'd0, in_ready}, 8'd1);

    // E, then A, then every letter and digit
    send(4);  drain("E", -1);
    send(0);  drain("A", -1);
    for (int c = 0; c < 36; c++) begin
      send(c);
      drain($sformatf("code%0d", c), -1);
    end

    // word space and invalid codes at the range edges
    send(36); drain("space", -1);
    send(37); drain("inv37", -1);
    send(50); drain("inv50", -1);
    send(63); drain("inv63", -1);

    // O aborted during the second dash (cycle 10)
    send(14);
    drain("O", 9);
    @(negedge clk);
    chk("O dash2 key",   {6'd0, key, 1'b0} | {6'd0, morse}, 8'd2 | 8'd2);
    chk("O dash2 morse", {6'd0, morse}, 8'd2);
    abort = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort state", {5'd0, out_state}, 8'd0);
    chk("abort key",   {7'd0, key}, 8'd0);
    chk("abort done",  {7'd0, done}, 8'd0);
    chk("abort ready", {7'd0, in_ready}, 8'd0);
    abort = 1'b0;
    q.delete();
    for (int k = 0; k < 4*U; k++) begin
      @(negedge clk);
      chk($sformatf("post-abort cyc%0d", k), {4'd0, done, err, key, in_ready}, 8'd1);
    end

    // Abort together with InValid in IDLE must not accept
    @(negedge clk);
    abort    = 1'b1;
    in_valid = 1'b1;
    code     = 6'd4;
    #1;
    chk("abort+valid ready", {7'd0, in_ready}, 8'd0);
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("no-accept cyc%0d", k), {2'd0, out_state, key, err, done}, 8'd0);
    end

    // reset mid-L during the dash, then H
    send(11);
    drain("L", 5);
    @(negedge clk);
    chk("L dash key", {7'd0, key}, 8'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("async rst key",   {7'd0, key}, 8'd0);
    chk("async rst morse", {6'd0, morse}, 8'd0);
    chk("async rst state", {5'd0, out_state}, 8'd0);
    chk("async rst done",  {6'd0, done, err}, 8'd0);
    q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post-rst ready", {7'd0, in_ready}, 8'd1);
    chk("post-rst key",   {7'd0, key}, 8'd0);
    send(7);  drain("H", -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard bound on simulated time
  initial begin
    #500000;
    $display("FAIL timeout reached observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/morse_keyer.md
MORSE_KEYER -- requirements
Module: morse_keyer

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 4, meaning Clock cycles per Morse time unit; legal range 1..255.
REQ-002 SHALL have parameter CODE_W, default 6, meaning width of the character code input; fixed at 6 for this generation.
REQ-003 SHALL have port Clock  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port Resetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port Code  input  CODE_W  character: 0-25 = A-Z, 26-35 = digits 0-9, 36 = word space, 37-63 = invalid.
REQ-006 SHALL have port InValid  input  1  Code is presented.
REQ-007 SHALL have port InReady  output  1  block can accept a character this cycle.
REQ-008 SHALL have port Abort  input  1  synchronous cancel of the character in progress.
REQ-009 SHALL have port Key  output  1  tone on (high during dot or dash elements).
REQ-010 SHALL have port Morse  output  2  current symbol: 0 = gap, 1 = dot, 2 = dash.
REQ-011 SHALL have port Done  output  1  one-cycle pulse when a character or space finishes, including its trailing gap.
REQ-012 SHALL have port Err  output  1  one-cycle pulse when an invalid code is accepted.
REQ-013 SHALL have port OutState  output  3  current FSM state, for debug.

Function
REQ-014 SHALL implement Moore FSM states IDLE, ELEM, EGAP, LGAP, WGAP; Key, Morse and InReady decode from registered state only.
REQ-015 SHALL drive InReady = (state==IDLE) && !Abort.
REQ-016 SHALL accept a character on a rising edge where InValid && InReady are both high.
REQ-017 SHALL, on accepting a valid letter or digit, load its pattern and length (1-5 elements, first element first) and enter ELEM on that same edge.
- Key therefore rises one cycle after the accept edge.
REQ-018 SHALL hold ELEM for 1 unit for a dot and 3 units for a dash (1 unit = UNIT_CYCLES cycles), with Key=1 and Morse = element type.
REQ-019 SHALL follow a non-final element with EGAP for 1 unit, then ELEM for the next element.
REQ-020 SHALL follow the final element with LGAP for 3 units, then IDLE, with Done high in the last LGAP cycle.
REQ-021 SHALL, on accepting code 36, enter WGAP for 7 units, then IDLE, with Done high in the last WGAP cycle.
REQ-022 SHALL, on accepting codes 37-63, pulse Err in the next cycle, stay in IDLE, and emit no Key activity.
REQ-023 SHALL drive Key=0 and Morse=0 in IDLE, EGAP, LGAP and WGAP.
REQ-024 SHALL use a single down-counter wide enough for 7*UNIT_CYCLES-1; each timed state loads it on entry and exits when the count reaches 0.
REQ-025 SHALL, on Abort high in any state, go to IDLE on the next edge with no Done and no Err.
- Abort has priority over a simultaneous InValid.
REQ-026 SHALL keep the latched pattern, length and element index stable while the character is sent; Code may change after acceptance without effect.

Reset
REQ-027 SHALL, while Resetn=0, force state IDLE, counter 0, element index 0 and pattern 0.
REQ-028 SHALL, during reset, hold outputs Key=0, Morse=0, Done=0, Err=0, OutState=IDLE, and InReady=1 once Resetn is released.
REQ-029 SHALL, if reset is asserted mid-character, abandon the character; it SHALL NOT resume after reset.

Structure
REQ-030 SHALL place in shared package morse_pkg:
- the state encoding,
- Morse symbol constants (GAP=0, DOT=1, DASH=2),
- CODE_SPACE=36 and MAX_LEN=5,
- unit multipliers (DASH=3, EGAP=1, LGAP=3, WGAP=7).
REQ-031 SHALL use one sub-module, morse_rom: a combinational map from Code to {valid, len[2:0], pattern[4:0]}, where a pattern bit of 1 = dash.

Verification (UNIT_CYCLES=2)
REQ-032 SHALL check the following:
- Reset then 'E' (code 4) → Key high 2 cycles starting 1 cycle after accept, then low 6; Done in cycle 8; InReady high in cycle 9.
- 'A' (code 0) → Key pattern 2 on, 2 off, 6 on, 6 off; Morse sequence 1,0,2,0.
- Code 36 → Key stays 0 for 14 cycles, then Done; code 50 → one Err pulse and InReady back high the next cycle.
- 'O' (code 14) with Abort asserted in the second dash → IDLE next cycle, Key 0, no Done; Abort and InValid together in IDLE → no accept.
- Resetn pulsed low mid-'L' (code 11) → all outputs 0 immediately (asynchronously); after release, InReady=1 and a new 'H' (code 7) sends 4 dots correctly.
